mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised MEM-stage load/store unit sitting between the EXE_MEM pipeline register, the data cache and the MEM_WB register. Converts a memory control word into a registered, held-stable cache request with byte enables and lane-shifted store data, waits for `mem_resp_d`, then sign/zero-extends load data and holds the result until writeback accepts it. Adds misalignment detection, an optional response timeout and XLEN 32/64 support.

## Interface
- `XLEN`, 32, datapath and cache word width; legal values 32 or 64
- `TIMEOUT`, 0, maximum BUSY cycles without `mem_resp_d`; 0 disables the timeout
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `exe_mem_valid`  in  1  EXE_MEM holds a valid instruction
- `mem_read`, `mem_write`  in  1 each  control-word memory op bits
- `funct3`  in  3  RISC-V width/sign code
- `addr`  in  XLEN  byte address
- `wdata`  in  XLEN  store data, LSB-justified
- `wb_ready`  in  1  MEM_WB can accept this cycle
- `mem_resp_d`  in  1  data cache response
- `mem_rdata_d`  in  XLEN  data cache read word
- `mem_r_d`, `mem_w_d`  out  1 each  cache read/write request
- `mem_addr_d`  out  XLEN  word-aligned address (low log2(XLEN/8) bits zero)
- `mem_byte_en_d`  out  XLEN/8  byte enables
- `mem_wdata_d`  out  XLEN  lane-shifted store data
- `mem_rdy`  out  1  result valid for MEM_WB
- `load_data`  out  XLEN  extended load result
- `misaligned`  out  1  op illegal/misaligned; valid with `mem_rdy`
- `timeout_err`  out  1  cache did not respond; valid with `mem_rdy`

## Operation
- Size from `funct3[1:0]`: 00 byte, 01 half, 10 word, 11 double. `funct3[2]`=1 means zero-extend (loads only).
- Illegal: size 11 with XLEN=32; `funct3`=110 with XLEN=32; `funct3[2]`=1 on stores; `funct3`=111. Misaligned: offset `addr[log2(XLEN/8)-1:0]` not a multiple of size bytes. Both set `misaligned`.
- `mem_read` and `mem_write` both high: treated as write.
- `mem_byte_en_d` = ((1<<bytes)-1) << offset. `mem_wdata_d` = `wdata` << (8*offset). Reads also drive byte enables.
- Load: shift `mem_rdata_d` right by 8*offset, truncate to size, then sign- or zero-extend to XLEN.
- FSM states:
  - IDLE: no request driven.
    - `exe_mem_valid` with no op, or an illegal/misaligned op → `mem_rdy`=1 combinationally this cycle, no cache request. For a bad op `misaligned`=1.
    - Legal op → latch addr/enables/wdata/type/offset; go to BUSY.
  - BUSY: `mem_r_d`/`mem_w_d` and all request outputs driven from registers, stable every cycle.
    - `mem_resp_d` → capture extended load (write: `load_data`=0); go to DONE.
    - Counter reaches `TIMEOUT` (nonzero) → go to DONE with `timeout_err`=1 and `load_data`=0.
    - `mem_resp_d` in the timeout cycle wins (no error).
  - DONE: `mem_rdy`=1, outputs held. `wb_ready` → IDLE. No new op is accepted in DONE.
- Upstream holds `exe_mem_valid` and its operands stable until it sees `mem_rdy` && `wb_ready`.
- In IDLE, combinational `mem_rdy` also requires `wb_ready` for the op to retire; otherwise the op is re-evaluated next cycle.

## Timing
- Reset (async) values:
  - state IDLE, counter 0
  - `mem_r_d`, `mem_w_d`, `mem_rdy`, `misaligned`, `timeout_err` = 0
  - `mem_addr_d`, `mem_byte_en_d`, `mem_wdata_d`, `load_data` = 0
- Reset asserted mid-BUSY drops the request immediately; nothing is replayed.
- Legal op in IDLE at cycle N → request high from N+1 until the cycle `mem_resp_d` is sampled (inclusive); request low from the next cycle. `mem_rdy` high from the cycle after response.
- Minimum legal-op latency is 2 cycles (zero-wait cache: request at N+1, `mem_rdy` at N+2).
- Timeout: counter clears on BUSY entry and increments each BUSY cycle without response. Error fires on the cycle the count equals `TIMEOUT`; DONE follows the next cycle.
- Non-memory or bad op: zero extra latency.

## Test plan
- LB at addr 0x1003, `mem_rdata_d`=0x80AA_BBCC, response after 3 wait cycles → `mem_byte_en_d`=1000, request held 4 cycles, `load_data`=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH at addr 0x2002, `wdata`=0x0000_1234 → `mem_w_d`=1, `mem_addr_d`=0x2000, `mem_byte_en_d`=1100, `mem_wdata_d`=0x1234_0000; `mem_rdy` held while `wb_ready`=0 for 2 cycles.
- LW at 0x3001 → `mem_rdy`=1 and `misaligned`=1 the same cycle, `mem_r_d` never asserted; SB with `funct3`=100 → `misaligned`=1.
- `TIMEOUT`=4, LW with no response → `timeout_err`=1 and `load_data`=0 on DONE; repeat with `mem_resp_d` in the 4th BUSY cycle → no error.
- XLEN=64: LD at 0x...8 with rdata 0x8000_0000_0000_0001 → sign-preserved; LWU at offset 4 → upper word zero-extended; LD with XLEN=32 → `misaligned`.
- Assert `rst` while in BUSY → `mem_r_d` low immediately, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Bundle of the MEM-stage load/store unit's pipeline-side and data-cache-side signals.
// The LSU connects through the slave modport; the surrounding pipeline/cache through master.
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
) ();
  logic              exe_mem_valid;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              wb_ready;
  logic              mem_resp_d;
  logic [XLEN-1:0]   mem_rdata_d;
  logic              mem_r_d;
  logic              mem_w_d;
  logic [XLEN-1:0]   mem_addr_d;
  logic [XLEN/8-1:0] mem_byte_en_d;
  logic [XLEN-1:0]   mem_wdata_d;
  logic              mem_rdy;
  logic [XLEN-1:0]   load_data;
  logic              misaligned;
  logic              timeout_err;

  modport slave (
    input  exe_mem_valid, mem_read, mem_write, funct3, addr, wdata, wb_ready,
    input  mem_resp_d, mem_rdata_d,
    output mem_r_d, mem_w_d, mem_addr_d, mem_byte_en_d, mem_wdata_d,
    output mem_rdy, load_data, misaligned, timeout_err
  );

  modport master (
    output exe_mem_valid, mem_read, mem_write, funct3, addr, wdata, wb_ready,
    output mem_resp_d, mem_rdata_d,
    input  mem_r_d, mem_w_d, mem_addr_d, mem_byte_en_d, mem_wdata_d,
    input  mem_rdy, load_data, misaligned, timeout_err
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns a memory control word into a held-stable cache request,
// then extends the load result and holds it until writeback accepts it.
module mem_stage_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input logic            clk,
  input logic            rst,
  mem_stage_lsu_if.slave bus
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              req_rd_r;
  logic              req_wr_r;
  logic [XLEN-1:0]   addr_r;
  logic [NB-1:0]     be_r;
  logic [XLEN-1:0]   wdata_r;
  logic [2:0]        off_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic              rdy_r;
  logic              tmo_r;
  logic [XLEN-1:0]   ld_r;

  logic              is_op_s;
  logic              is_wr_s;
  logic [1:0]        size_s;
  logic [2:0]        off_s;
  logic              illegal_s;
  logic              misal_s;
  logic              bad_s;
  logic [NB-1:0]     be_s;
  logic [XLEN-1:0]   wdata_sh_s;
  logic [XLEN-1:0]   addr_al_s;
  logic              idle_retire_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  // Contiguous byte-lane mask of 2**size bytes starting at lane 'off'.
  function automatic logic [NB-1:0] byte_enables(input logic [2:0] off, input logic [1:0] size);
    logic [NB-1:0] be;
    int lo;
    int hi;
    lo = int'(off);
    hi = lo + (32'sd1 << size);
    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= lo) && (i < hi);
    end
    return be;
  endfunction

  // Select the addressed lanes of the cache word and sign- or zero-extend them.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size,
                                                  input logic            uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ext;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00: begin
        if (uns) ext = XLEN'(sh[7:0]);
        else     ext = XLEN'($signed(sh[7:0]));
      end
      2'b01: begin
        if (uns) ext = XLEN'(sh[15:0]);
        else     ext = XLEN'($signed(sh[15:0]));
      end
      2'b10: begin
        if (uns) ext = XLEN'(sh[31:0]);
        else     ext = XLEN'($signed(sh[31:0]));
      end
      default: ext = sh;
    endcase
    return ext;
  endfunction

  // Decode the incoming control word: legality, alignment, lane placement.
  always_comb begin
    is_op_s    = bus.mem_read | bus.mem_write;
    is_wr_s    = bus.mem_write;
    size_s     = bus.funct3[1:0];
    off_s      = 3'(bus.addr[OFF_W-1:0]);
    illegal_s  = 1'b0;
    if (bus.funct3 == 3'b111) begin
      illegal_s = 1'b1;
    end else if (is_wr_s && bus.funct3[2]) begin
      illegal_s = 1'b1;
    end else if ((XLEN == 32) && ((size_s == 2'b11) || (bus.funct3 == 3'b110))) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
    case (size_s)
      2'b00:   misal_s = 1'b0;
      2'b01:   misal_s = off_s[0];
      2'b10:   misal_s = |off_s[1:0];
      2'b11:   misal_s = |off_s;
      default: misal_s = 1'b0;
    endcase
    bad_s      = illegal_s | misal_s;
    be_s       = byte_enables(off_s, size_s);
    wdata_sh_s = bus.wdata << {off_s, 3'b000};
    addr_al_s  = {bus.addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    // Non-memory and rejected ops retire straight out of IDLE with no cache traffic.
    idle_retire_s = (state_r == ST_IDLE) && bus.exe_mem_valid && (!is_op_s || bad_s) && bus.wb_ready;
    cnt_inc_s  = cnt_r + CNT_W'(32'd1);
  end

  // Request/response sequencing with registered cache request and writeback result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      req_rd_r <= 1'b0;
      req_wr_r <= 1'b0;
      addr_r   <= '0;
      be_r     <= '0;
      wdata_r  <= '0;
      off_r    <= 3'b000;
      size_r   <= 2'b00;
      uns_r    <= 1'b0;
      rdy_r    <= 1'b0;
      tmo_r    <= 1'b0;
      ld_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.exe_mem_valid && is_op_s && !bad_s) begin
            req_rd_r <= !is_wr_s;
            req_wr_r <= is_wr_s;
            addr_r   <= addr_al_s;
            be_r     <= be_s;
            wdata_r  <= wdata_sh_s;
            off_r    <= off_s;
            size_r   <= size_s;
            uns_r    <= bus.funct3[2];
            cnt_r    <= '0;
            state_r  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A response arriving in the timeout cycle takes priority over the error.
          if (bus.mem_resp_d) begin
            req_rd_r <= 1'b0;
            req_wr_r <= 1'b0;
            ld_r     <= req_wr_r ? '0 : extend_load(bus.mem_rdata_d, off_r, size_r, uns_r);
            tmo_r    <= 1'b0;
            rdy_r    <= 1'b1;
            state_r  <= ST_DONE;
          end else if ((TIMEOUT != 0) && (cnt_inc_s == CNT_W'(TIMEOUT))) begin
            req_rd_r <= 1'b0;
            req_wr_r <= 1'b0;
            ld_r     <= '0;
            tmo_r    <= 1'b1;
            rdy_r    <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            cnt_r    <= cnt_inc_s;
          end
        end
        ST_DONE: begin
          if (bus.wb_ready) begin
            rdy_r   <= 1'b0;
            tmo_r   <= 1'b0;
            ld_r    <= '0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          req_rd_r <= 1'b0;
          req_wr_r <= 1'b0;
          rdy_r    <= 1'b0;
          tmo_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_r_d       = req_rd_r;
  assign bus.mem_w_d       = req_wr_r;
  assign bus.mem_addr_d    = addr_r;
  assign bus.mem_byte_en_d = be_r;
  assign bus.mem_wdata_d   = wdata_r;
  assign bus.mem_rdy       = rdy_r | idle_retire_s;
  assign bus.load_data     = ld_r;
  assign bus.misaligned    = idle_retire_s & is_op_s & bad_s;
  assign bus.timeout_err   = tmo_r;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu: a 32-bit (TIMEOUT=4) and a 64-bit (no timeout) instance
// share one stimulus stream and are checked against a spec-level reference model.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        valid;
  logic        rd;
  logic        wr;
  logic [2:0]  f3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        wb_rdy;
  logic        resp;

  logic        o_rd, o_wr, o_rdy, o_mis, o_tmo;
  logic [63:0] o_addr, o_wd, o_ld;
  logic [7:0]  o_be;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.XLEN(32)) if32 ();
  mem_stage_lsu_if #(.XLEN(64)) if64 ();

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(4)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  mem_stage_lsu #(.XLEN(64), .TIMEOUT(0)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

  assign if32.exe_mem_valid = valid & ~sel;
  assign if32.mem_read      = rd;
  assign if32.mem_write     = wr;
  assign if32.funct3        = f3;
  assign if32.addr          = addr[31:0];
  assign if32.wdata         = wdata[31:0];
  assign if32.wb_ready      = wb_rdy;
  assign if32.mem_resp_d    = resp & ~sel;
  assign if32.mem_rdata_d   = rdata[31:0];

  assign if64.exe_mem_valid = valid & sel;
  assign if64.mem_read      = rd;
  assign if64.mem_write     = wr;
  assign if64.funct3        = f3;
  assign if64.addr          = addr;
  assign if64.wdata         = wdata;
  assign if64.wb_ready      = wb_rdy;
  assign if64.mem_resp_d    = resp & sel;
  assign if64.mem_rdata_d   = rdata;

  always_comb begin
    if (sel) begin
      o_rd = if64.mem_r_d;  o_wr = if64.mem_w_d;  o_rdy = if64.mem_rdy;
      o_mis = if64.misaligned;  o_tmo = if64.timeout_err;
      o_addr = if64.mem_addr_d;  o_wd = if64.mem_wdata_d;  o_ld = if64.load_data;
      o_be = if64.mem_byte_en_d;
    end else begin
      o_rd = if32.mem_r_d;  o_wr = if32.mem_w_d;  o_rdy = if32.mem_rdy;
      o_mis = if32.misaligned;  o_tmo = if32.timeout_err;
      o_addr = {32'h0, if32.mem_addr_d};  o_wd = {32'h0, if32.mem_wdata_d};
      o_ld = {32'h0, if32.load_data};  o_be = {4'h0, if32.mem_byte_en_d};
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (xlen=%0d t=%0t)", tag, got, exp, sel ? 64 : 32, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rdy"}, {63'd0, o_rdy}, 64'd0);
    check_eq({tag, "_req"}, {62'd0, o_rd, o_wr}, 64'd0);
    check_eq({tag, "_addr"}, o_addr, 64'd0);
    check_eq({tag, "_be"}, {56'd0, o_be}, 64'd0);
    check_eq({tag, "_wd"}, o_wd, 64'd0);
    check_eq({tag, "_ld"}, o_ld, 64'd0);
    check_eq({tag, "_flags"}, {62'd0, o_mis, o_tmo}, 64'd0);
  endtask

  // One op from presentation in IDLE to retirement; expectations come from the op rules.
  task automatic run_op(input logic s, input logic r, input logic w, input logic [2:0] f,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] word,
                        input int delay, input int wbwait);
    int xlen, nb, off, size, to, busy, k;
    logic op, bad, tmo;
    logic [63:0] xmask, m, v, exp_ld;
    xlen  = s ? 64 : 32;
    nb    = xlen / 8;
    to    = s ? 0 : 4;
    xmask = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    off   = int'(a[2:0]) % nb;
    size  = 1 << f[1:0];
    op    = r | w;
    bad   = (f == 3'b111) || (w && f[2]) || (xlen == 32 && (size == 8 || f == 3'b110)) || (off % size != 0);

    @(negedge clk);
    sel = s; valid = 1'b1; rd = r; wr = w; f3 = f; addr = a; wdata = wd; rdata = word;
    wb_rdy = 1'b1; resp = 1'b0;
    #1;
    if (!op || bad) begin
      check_eq("idle_rdy", {63'd0, o_rdy}, 64'd1);
      check_eq("idle_mis", {63'd0, o_mis}, {63'd0, op & bad});
      check_eq("idle_noreq", {62'd0, o_rd, o_wr}, 64'd0);
      @(negedge clk);
      valid = 1'b0;
      return;
    end
    check_eq("accept_rdy", {63'd0, o_rdy}, 64'd0);

    tmo  = (to != 0) && (delay >= to);
    busy = tmo ? to : delay + 1;
    m    = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    v    = ((word & xmask) >> (8 * off)) & m;
    if (!f[2] && size < 8 && v[8 * size - 1]) v = v | ~m;
    exp_ld = (w || tmo) ? 64'd0 : (v & xmask);

    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (o_rdy) break;
      if (k == 1) begin
        check_eq("req_dir", {62'd0, o_rd, o_wr}, {62'd0, ~w, w});
        check_eq("req_addr", o_addr, a & ~64'(nb - 1) & xmask);
        check_eq("req_be", {56'd0, o_be}, ((64'd1 << size) - 64'd1) << off);
        check_eq("req_wd", o_wd, ((wd & xmask) << (8 * off)) & xmask);
      end
      check_eq("req_held", {63'd0, o_rd | o_wr}, 64'd1);
      resp = (k == delay + 1);
    end
    resp = 1'b0;
    check_eq("latency", 64'(k), 64'(busy + 1));
    check_eq("done_ld", o_ld, exp_ld);
    check_eq("done_tmo", {63'd0, o_tmo}, {63'd0, tmo});
    check_eq("done_mis", {63'd0, o_mis}, 64'd0);
    check_eq("done_noreq", {62'd0, o_rd, o_wr}, 64'd0);

    if (wbwait > 0) wb_rdy = 1'b0;
    for (int i = 0; i < wbwait; i++) begin
      @(negedge clk);
      #1;
      check_eq("hold_rdy", {63'd0, o_rdy}, 64'd1);
      check_eq("hold_ld", o_ld, exp_ld);
    end
    wb_rdy = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    #1;
    check_eq("retired", {63'd0, o_rdy}, 64'd0);
  endtask

  initial begin
    logic        s, r, w;
    logic [2:0]  f;
    logic [63:0] a;
    int          kind;

    rst = 1'b1; sel = 1'b0; valid = 1'b0; rd = 1'b0; wr = 1'b0; f3 = 3'b000;
    addr = 64'd0; wdata = 64'd0; rdata = 64'd0; wb_rdy = 1'b0; resp = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("rst32");
    sel = 1'b1;
    #1;
    check_all_zero("rst64");
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h80AA_BBCC, 3, 0);
    run_op(1'b0, 1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 64'h80AA_BBCC, 3, 0);
    run_op(1'b0, 1'b0, 1'b1, 3'b001, 64'h2002, 64'h1234, 64'h0, 0, 2);
    run_op(1'b0, 1'b1, 1'b0, 3'b010, 64'h3001, 64'h0, 64'h0, 0, 0);
    run_op(1'b0, 1'b0, 1'b1, 3'b100, 64'h0010, 64'h55, 64'h0, 0, 0);
    run_op(1'b0, 1'b1, 1'b0, 3'b010, 64'h4000, 64'h0, 64'hDEAD_BEEF, 100, 0);
    run_op(1'b0, 1'b1, 1'b0, 3'b010, 64'h4000, 64'h0, 64'hDEAD_BEEF, 3, 0);
    run_op(1'b1, 1'b1, 1'b0, 3'b011, 64'h0000_0001_0000_0008, 64'h0, 64'h8000_0000_0000_0001, 2, 0);
    run_op(1'b1, 1'b1, 1'b0, 3'b110, 64'h0000_0001_0000_0004, 64'h0, 64'h8765_4321_0000_0000, 1, 1);
    run_op(1'b0, 1'b1, 1'b0, 3'b011, 64'h0008, 64'h0, 64'h0, 0, 0);
    run_op(1'b1, 1'b0, 1'b0, 3'b010, 64'h0003, 64'h0, 64'h0, 0, 0);
    run_op(1'b1, 1'b1, 1'b1, 3'b010, 64'h0000_0000_0000_0104, 64'hCAFE_F00D, 64'h0, 0, 0);

    for (int t = 0; t < 120; t++) begin
      s    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      r    = (kind >= 1 && kind <= 5) || kind == 9;
      w    = (kind >= 6);
      f    = 3'($urandom_range(0, 7));
      a    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f[1:0]) - 64'd1);
      run_op(s, r, w, f, a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 5), $urandom_range(0, 2));
    end

    // Reset asserted while a load is outstanding drops everything at once.
    @(negedge clk);
    sel = 1'b0; valid = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 64'h40; wb_rdy = 1'b1;
    @(negedge clk);
    #1;
    check_eq("pre_rst_req", {63'd0, o_rd}, 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("no_replay", {62'd0, o_rd, o_wr}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
